// File: rtl/mips_cpu_pkg.sv
// Shared constants for the multicycle MIPS bus CPU: opcodes, funct codes,
// FSM state encoding and the reset vector.
package mips_cpu_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        EXEC   = 3'd1,
        MEM    = 3'd2,
        WB     = 3'd3,
        HALTED = 3'd4
    } state_t;

endpackage

// File: rtl/mips_cpu_regfile.sv
// 32x32 general-purpose register file: two async read ports, one sync write
// port, $0 hardwired to zero, and a live tap of $2 (v0).
module mips_cpu_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_v0
);

    logic [31:0] r_regs [32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (i_we && (i_wa != 5'd0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'h0 : r_regs[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'h0 : r_regs[i_ra2];
    assign o_v0  = r_regs[2];

endmodule

// File: rtl/mips_cpu_bus.sv
// Multicycle MIPS subset CPU on a single Avalon-style bus: one transfer at a
// time, FETCH/EXEC/MEM/WB, halts when the next fetch address would be zero.
module mips_cpu_bus
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    state_t      r_state, w_next;
    logic [31:0] r_pc, r_ir, r_target, r_mdr;
    logic        r_delay;

    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_a, w_b, w_sext, w_zext, w_ea, w_pc_next;
    logic [31:0] w_alu_res, w_rf_wd;
    logic [4:0]  w_alu_wa, w_rf_wa;
    logic        w_alu_we, w_rf_we, w_is_jr, w_is_lw, w_is_sw;

    assign w_op   = r_ir[31:26];
    assign w_rs   = r_ir[25:21];
    assign w_rt   = r_ir[20:16];
    assign w_rd   = r_ir[15:11];
    assign w_fn   = r_ir[5:0];
    assign w_sext = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_zext = {16'h0, r_ir[15:0]};
    assign w_ea   = w_a + w_sext;

    // A pending JR target replaces the sequential PC once the delay slot has run.
    assign w_pc_next = r_delay ? r_target : (r_pc + 32'd4);

    mips_cpu_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .o_rd1 (w_a),
        .o_rd2 (w_b),
        .i_we  (w_rf_we),
        .i_wa  (w_rf_wa),
        .i_wd  (w_rf_wd),
        .o_v0  (register_v0)
    );

    always_comb begin
        w_alu_we  = 1'b0;
        w_alu_wa  = w_rt;
        w_alu_res = 32'h0;
        w_is_jr   = 1'b0;
        w_is_lw   = 1'b0;
        w_is_sw   = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_alu_wa = w_rd;
                case (w_fn)
                    FN_ADDU: begin w_alu_we = 1'b1; w_alu_res = w_a + w_b; end
                    FN_SUBU: begin w_alu_we = 1'b1; w_alu_res = w_a - w_b; end
                    FN_AND:  begin w_alu_we = 1'b1; w_alu_res = w_a & w_b; end
                    FN_OR:   begin w_alu_we = 1'b1; w_alu_res = w_a | w_b; end
                    FN_XOR:  begin w_alu_we = 1'b1; w_alu_res = w_a ^ w_b; end
                    FN_SLTU: begin w_alu_we = 1'b1; w_alu_res = {31'h0, (w_a < w_b)}; end
                    FN_JR:   w_is_jr = 1'b1;
                    default: ;
                endcase
            end
            OP_ADDIU: begin w_alu_we = 1'b1; w_alu_res = w_a + w_sext; end
            OP_ANDI:  begin w_alu_we = 1'b1; w_alu_res = w_a & w_zext; end
            OP_ORI:   begin w_alu_we = 1'b1; w_alu_res = w_a | w_zext; end
            OP_XORI:  begin w_alu_we = 1'b1; w_alu_res = w_a ^ w_zext; end
            OP_LUI:   begin w_alu_we = 1'b1; w_alu_res = {r_ir[15:0], 16'h0}; end
            OP_LW:    w_is_lw = 1'b1;
            OP_SW:    w_is_sw = 1'b1;
            default: ;
        endcase
    end

    assign w_rf_we = ((r_state == EXEC) && w_alu_we) || (r_state == WB);
    assign w_rf_wa = (r_state == WB) ? w_rt  : w_alu_wa;
    assign w_rf_wd = (r_state == WB) ? r_mdr : w_alu_res;

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:  if (!waitrequest) w_next = EXEC;
            EXEC: begin
                if (w_is_lw || w_is_sw)      w_next = MEM;
                else if (w_pc_next == 32'h0) w_next = HALTED;
                else                         w_next = FETCH;
            end
            // r_pc already holds the next fetch address once EXEC has retired.
            MEM: begin
                if (!waitrequest) begin
                    if (w_is_lw)             w_next = WB;
                    else if (r_pc == 32'h0)  w_next = HALTED;
                    else                     w_next = FETCH;
                end
            end
            WB:     w_next = (r_pc == 32'h0) ? HALTED : FETCH;
            HALTED: w_next = HALTED;
            default: w_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= FETCH;
            r_pc     <= RESET_VECTOR;
            r_ir     <= 32'h0;
            r_target <= 32'h0;
            r_delay  <= 1'b0;
            r_mdr    <= 32'h0;
        end else begin
            r_state <= w_next;
            if ((r_state == FETCH) && !waitrequest) r_ir <= readdata;
            if (r_state == EXEC) begin
                r_pc    <= w_pc_next;
                r_delay <= w_is_jr;
                if (w_is_jr) r_target <= w_a;
            end
            if ((r_state == MEM) && !waitrequest && w_is_lw) r_mdr <= readdata;
        end
    end

    assign active     = (r_state != HALTED);
    assign read       = (r_state == FETCH) || ((r_state == MEM) && w_is_lw);
    assign write      = (r_state == MEM) && w_is_sw;
    assign address    = (r_state == MEM) ? (w_ea & 32'hFFFF_FFFC) : r_pc;
    assign writedata  = w_b;
    assign byteenable = 4'b1111;

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Self-checking bench for mips_cpu_bus: an instruction-level model predicts the
// bus transfer sequence and final v0; a bus responder serves memory with stalls.
module tb_mips_cpu_bus;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        active, write, read, waitrequest;
    logic [31:0] register_v0, address, writedata, readdata;
    logic [3:0]  byteenable;

    initial forever #5 clk = ~clk;

    mips_cpu_bus dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] v0;
    } xfer_t;

    xfer_t       expq[$];
    logic [31:0] mmem [logic [31:0]];
    logic [31:0] bmem [logic [31:0]];
    int          n_checks = 0, n_fail = 0;
    int          stall_mode = 0;
    bit          chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mrd(input logic [31:0] a, input bit bus);
        if (bus) return bmem.exists(a) ? bmem[a] : 32'h0;
        return mmem.exists(a) ? mmem[a] : 32'h0;
    endfunction

    task automatic put(input logic [31:0] a, input logic [31:0] v);
        mmem[a] = v;
        bmem[a] = v;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Instruction-level interpreter: each instruction yields its fetch, plus
    // one data transfer for LW/SW; v0 is the architectural value at that point.
    task automatic build_model(output logic [31:0] fv0);
        logic [31:0] g [32];
        logic [31:0] pc, npc, tgt, ir, ea, res, sx, zx;
        logic [4:0]  rs, rt, rd, dst;
        logic [5:0]  op, fn;
        bit          dly, wr;
        int          steps;
        foreach (g[i]) g[i] = 32'h0;
        pc = 32'hBFC00000; tgt = 32'h0; dly = 1'b0; steps = 0;
        expq.delete();
        while (pc != 32'h0 && steps < 4000) begin
            ir = mrd(pc, 1'b0);
            expq.push_back('{wr: 1'b0, addr: pc, data: 32'h0, v0: g[2]});
            op = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11]; fn = ir[5:0];
            sx = {{16{ir[15]}}, ir[15:0]};
            zx = {16'h0, ir[15:0]};
            npc = dly ? tgt : pc + 32'd4;
            dly = 1'b0; wr = 1'b0; res = 32'h0; dst = rt;
            case (op)
                6'h00: begin
                    dst = rd; wr = 1'b1;
                    case (fn)
                        6'h21: res = g[rs] + g[rt];
                        6'h23: res = g[rs] - g[rt];
                        6'h24: res = g[rs] & g[rt];
                        6'h25: res = g[rs] | g[rt];
                        6'h26: res = g[rs] ^ g[rt];
                        6'h2B: res = (g[rs] < g[rt]) ? 32'd1 : 32'd0;
                        6'h08: begin wr = 1'b0; tgt = g[rs]; dly = 1'b1; end
                        default: wr = 1'b0;
                    endcase
                end
                6'h09: begin wr = 1'b1; res = g[rs] + sx; end
                6'h0C: begin wr = 1'b1; res = g[rs] & zx; end
                6'h0D: begin wr = 1'b1; res = g[rs] | zx; end
                6'h0E: begin wr = 1'b1; res = g[rs] ^ zx; end
                6'h0F: begin wr = 1'b1; res = {ir[15:0], 16'h0}; end
                6'h23: begin
                    ea = (g[rs] + sx) & 32'hFFFF_FFFC;
                    expq.push_back('{wr: 1'b0, addr: ea, data: 32'h0, v0: g[2]});
                    wr = 1'b1; res = mrd(ea, 1'b0);
                end
                6'h2B: begin
                    ea = (g[rs] + sx) & 32'hFFFF_FFFC;
                    expq.push_back('{wr: 1'b1, addr: ea, data: g[rt], v0: g[2]});
                    mmem[ea] = g[rt];
                end
                default: ;
            endcase
            if (wr && dst != 5'd0) g[dst] = res;
            pc = npc;
            steps++;
        end
        fv0 = g[2];
    endtask

    // Bus responder plus the per-cycle transfer compare against the model queue.
    initial begin
        bit          stalling;
        int          left;
        logic [31:0] s_addr, s_wd;
        logic        s_rd, s_wr;
        xfer_t       h;
        waitrequest = 1'b0; readdata = 32'h0;
        stalling = 1'b0; left = 0;
        s_addr = 32'h0; s_wd = 32'h0; s_rd = 1'b0; s_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                waitrequest = 1'b0; stalling = 1'b0; left = 0;
                continue;
            end
            if (read || write) begin
                if (chk_en) begin
                    check("rd_wr_exclusive", {31'h0, read & write}, 32'h0);
                    check("byteenable", {28'h0, byteenable}, 32'hF);
                end
                if (stalling) begin
                    if (chk_en) begin
                        check("stall_addr", address, s_addr);
                        check("stall_read", {31'h0, read}, {31'h0, s_rd});
                        check("stall_write", {31'h0, write}, {31'h0, s_wr});
                        if (s_wr) check("stall_wdata", writedata, s_wd);
                    end
                end else begin
                    if (chk_en) begin
                        if (expq.size() == 0) begin
                            check("unexpected_xfer", address, 32'hFFFF_FFFF);
                        end else begin
                            h = expq[0];
                            check("xfer_kind", {31'h0, write}, {31'h0, h.wr});
                            check("xfer_addr", address, h.addr);
                            if (h.wr) check("xfer_wdata", writedata, h.data);
                            check("xfer_v0", register_v0, h.v0);
                        end
                    end
                    s_addr = address; s_wd = writedata; s_rd = read; s_wr = write;
                    left = (stall_mode == 1) ? int'($urandom_range(0, 2)) : stall_mode;
                end
                if (left > 0) begin
                    waitrequest = 1'b1; readdata = $urandom; stalling = 1'b1; left--;
                end else begin
                    waitrequest = 1'b0; stalling = 1'b0;
                    if (read) readdata = mrd(address, 1'b1);
                    else      bmem[address] = writedata;
                    if (chk_en && expq.size() != 0) void'(expq.pop_front());
                end
            end else begin
                waitrequest = 1'b0; stalling = 1'b0;
            end
        end
    end

    task automatic run_prog(input string nm, input int mode, input bit use_lit,
                            input logic [31:0] lit_v0, input bit mid_lw_reset);
        logic [31:0] fv0;
        int          cyc;
        build_model(fv0);
        if (use_lit) check({nm, "_model_v0"}, fv0, lit_v0);
        stall_mode = mode;
        chk_en = 1'b0;
        if (mid_lw_reset) begin
            @(posedge clk); #2 reset = 1'b1;
            @(posedge clk); #2 reset = 1'b0;
            cyc = 0;
            do begin @(negedge clk); cyc++; end
            while (!(read && address == 32'h4) && cyc < 200);
            check({nm, "_reach_lw"}, address, 32'h4);
        end
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk); #1;
        check({nm, "_rst_active"}, {31'h0, active}, 32'h1);
        check({nm, "_rst_read"}, {31'h0, read}, 32'h1);
        check({nm, "_rst_write"}, {31'h0, write}, 32'h0);
        check({nm, "_rst_addr"}, address, 32'hBFC00000);
        check({nm, "_rst_v0"}, register_v0, 32'h0);
        @(posedge clk); #2 reset = 1'b0; chk_en = 1'b1;
        @(negedge clk); #1;
        check({nm, "_post_active"}, {31'h0, active}, 32'h1);
        check({nm, "_post_addr"}, address, 32'hBFC00000);
        check({nm, "_post_rw"}, {30'h0, read, write}, 32'h2);
        check({nm, "_post_be"}, {28'h0, byteenable}, 32'hF);
        cyc = 0;
        while (active && cyc < 5000) begin @(negedge clk); cyc++; end
        #1;
        check({nm, "_halted"}, {31'h0, active}, 32'h0);
        check({nm, "_v0"}, register_v0, fv0);
        check({nm, "_xfers_left"}, expq.size(), 32'h0);
        repeat (4) @(negedge clk);
        #1;
        check({nm, "_idle_bus"}, {30'h0, read, write}, 32'h0);
        check({nm, "_v0_frozen"}, register_v0, fv0);
    endtask

    task automatic load_subu(input logic [31:0] m4, input logic [31:0] m8);
        mmem.delete(); bmem.delete();
        put(32'hBFC00000, enc_i(6'h23, 5'd0, 5'd3, 16'h0004));
        put(32'hBFC00004, enc_i(6'h23, 5'd0, 5'd4, 16'h0008));
        put(32'hBFC00008, enc_r(5'd0, 5'd0, 5'd0, 6'h08));
        put(32'hBFC0000C, enc_r(5'd3, 5'd4, 5'd2, 6'h23));
        put(32'h4, m4);
        put(32'h8, m8);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] fns [6] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2B};
        logic [5:0] ops [5] = '{6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        int k;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        k = $urandom_range(0, 9);
        if (k <= 3) return enc_r(rs, rt, rd, fns[$urandom_range(0, 5)]);
        if (k <= 6) return enc_i(ops[$urandom_range(0, 4)], rs, rt, imm);
        imm = 16'h0100 + 16'($urandom_range(0, 63));
        if (k == 7) return enc_i(6'h23, 5'd0, rt, imm);
        if (k == 8) return enc_i(6'h2B, 5'd0, rt, imm);
        if ($urandom_range(0, 1) == 0) return {6'h3F, 26'($urandom)};
        return enc_r(rs, rt, rd, 6'h00);
    endfunction

    task automatic load_random();
        logic [31:0] a;
        mmem.delete(); bmem.delete();
        a = 32'hBFC00000;
        for (int r = 1; r < 8; r++) begin
            put(a, enc_i(6'h0F, 5'd0, 5'(r), 16'($urandom))); a += 4;
            put(a, enc_i(6'h0D, 5'(r), 5'(r), 16'($urandom))); a += 4;
        end
        for (int n = 0; n < 30; n++) begin put(a, rand_instr()); a += 4; end
        put(a, enc_r(5'd0, 5'd0, 5'd0, 6'h08)); a += 4;
        put(a, 32'h0);
        for (int w = 0; w < 16; w++) put(32'h100 + 32'(w * 4), $urandom);
    endtask

    initial begin
        load_subu(32'd7, 32'd3);
        run_prog("subu", 0, 1'b1, 32'd4, 1'b0);

        load_subu(32'd0, 32'd1);
        run_prog("subu_wrap", 0, 1'b1, 32'hFFFFFFFF, 1'b0);

        load_subu(32'd7, 32'd3);
        run_prog("stall3", 3, 1'b1, 32'd4, 1'b0);

        mmem.delete(); bmem.delete();
        put(32'hBFC00000, enc_i(6'h09, 5'd0, 5'd5, 16'h1234));
        put(32'hBFC00004, enc_i(6'h2B, 5'd0, 5'd5, 16'h0010));
        put(32'hBFC00008, enc_i(6'h23, 5'd0, 5'd2, 16'h0010));
        put(32'hBFC0000C, enc_r(5'd0, 5'd0, 5'd0, 6'h08));
        put(32'hBFC00010, 32'h0);
        run_prog("sw_lw", 1, 1'b1, 32'h00001234, 1'b0);

        load_subu(32'd7, 32'd3);
        run_prog("mid_lw_reset", 3, 1'b1, 32'd4, 1'b1);

        for (int t = 0; t < 5; t++) begin
            load_random();
            run_prog($sformatf("rand%0d", t), (t == 0) ? 0 : 1, 1'b0, 32'h0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus.md
MIPS_CPU_BUS -- requirements
Module: mips_cpu_bus

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 active  out  1  high while CPU executes; low once halted.
REQ-005 register_v0  out  32  live contents of GPR $2 (v0).
REQ-006 address  out  32  byte address of current bus transfer; always word-aligned (bits[1:0]=0).
REQ-007 write  out  1  write request.
REQ-008 read  out  1  read request.
REQ-009 waitrequest  in  1  slave stall; current transfer must be held while high.
REQ-010 writedata  out  32  store data.
REQ-011 byteenable  out  4  byte lanes; 4'b1111 for all supported transfers.
REQ-012 readdata  in  32  load/fetch data, valid in the cycle read=1 and waitrequest=0.

Function
REQ-013 Multicycle FSM with states FETCH, EXEC, MEM, WB, HALTED; one bus transfer at a time; read and write never both high.
REQ-014 FETCH: address=PC, read=1, byteenable=1111; IR captured on the rising edge where waitrequest=0; then EXEC.
REQ-015 Any state issuing a transfer holds address/read/write/writedata/byteenable stable and does not advance while waitrequest=1.
REQ-016 Supported instructions: ADDU, SUBU, AND, OR, XOR, SLTU, JR, ADDIU, ANDI, ORI, XORI, LUI, LW, SW; any other encoding executes as NOP.
REQ-017 Arithmetic is 32-bit modulo 2^32, no overflow traps (SUBU 0-1 = 32'hFFFFFFFF).
REQ-018 ADDIU/LW/SW sign-extend imm16; ANDI/ORI/XORI zero-extend; LUI = imm16<<16.
REQ-019 R-type and I-type ALU results written to rd/rt at the end of EXEC; then FETCH.
REQ-020 LW/SW: effective address = rs + sext(imm); MEM issues read (LW) or write with writedata=rt (SW); LW writes readdata to rt in WB; SW returns to FETCH after MEM.
REQ-021 Writes to $0 are discarded; $0 always reads 0.
REQ-022 PC advances by 4 per instruction; JR has one branch delay slot: target=rs latched, delay-slot instruction executes, then PC=target.
REQ-023 Halt: when the next fetch address equals 32'h00000000, enter HALTED instead of FETCH; active=0, read=0, write=0, no further bus activity, registers frozen.
REQ-024 HALTED is left only by reset.
REQ-025 LW/SW effective address with bits[1:0]≠0: bits[1:0] are forced to 0 for the transfer.

Reset
REQ-026 reset=1 immediately forces: PC=32'hBFC00000, state=FETCH, all 32 GPRs=0, delay-slot flag clear, active=1.
REQ-027 While reset=1 and in the first cycle after release: read=1, write=0, address=32'hBFC00000, byteenable=1111.
REQ-028 Reset asserted mid-transfer aborts it; no register or memory write from that transfer occurs.

Structure
REQ-029 Shared package mips_cpu_pkg: opcode and funct constants, FSM state enum, reset vector 32'hBFC00000.
REQ-030 One sub-module: mips_cpu_regfile (32x32, two async read ports, one sync write port, $0 hardwired, v0 tap output).
REQ-031 Memory model mips_cpu_ram (parameter RAM_INIT_FILE, same bus port list, word-addressed hex init) is bench infrastructure, not part of this block.

Verification
REQ-032 Reset sequence: reset 1 cycle high then low -> next falling edge active=1, address=BFC00000, read=1, write=0, byteenable=1111.
REQ-033 SUBU: lw $3,4($0); lw $4,8($0); jr $0; subu $2,$3,$4 with mem[4]=7, mem[8]=3 -> halts, active=0, register_v0=4.
REQ-034 SUBU wrap: same program with mem[4]=0, mem[8]=1 -> register_v0=32'hFFFFFFFF.
REQ-035 Waitrequest: RAM asserts waitrequest 3 cycles on every transfer -> identical v0 result; bus signals stable during stall.
REQ-036 SW/LW round trip: addiu $5,$0,0x1234; sw $5,0x10($0); lw $2,0x10($0); jr $0; nop -> v0=32'h00001234.
REQ-037 Reset pulse mid-LW -> restart at BFC00000, GPRs 0, final v0 matches clean run.
